// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: FU completion record, ROB tag width and the ROB-age compare.
package riscv_pkg;

  localparam int unsigned XLEN                  = 32;
  localparam int unsigned ReorderBufferTagWidth = 5;

  typedef struct packed {
    logic                             valid;
    logic [ReorderBufferTagWidth-1:0] tag;
    logic [XLEN-1:0]                  value;
  } fu_complete_t;

  // Ages are measured from the ROB head; the extra MSB keeps wrapped tags ordered after unwrapped ones.
  function automatic logic is_younger(
    input logic [ReorderBufferTagWidth-1:0] entry_tag,
    input logic [ReorderBufferTagWidth-1:0] flush_tag,
    input logic [ReorderBufferTagWidth-1:0] head
  );
    logic [ReorderBufferTagWidth:0] age_entry;
    logic [ReorderBufferTagWidth:0] age_flush;
    age_entry = {1'b0, entry_tag} - {1'b0, head};
    age_flush = {1'b0, flush_tag} - {1'b0, head};
    return age_entry > age_flush;
  endfunction

endpackage

// File: rtl/fu_cdb_adapter.sv
// Per-FU completion FIFO feeding one CDB arbiter slot, with flush kill and back-pressure.
// Optional same-cycle bypass when the buffer holds no live entries: FU_CDB_ADAPTER_BYPASS_EN.
module fu_cdb_adapter
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  fu_complete_t                     i_fu_complete,
  output fu_complete_t                     o_fu_complete,
  input  logic                             i_grant,
  output logic                             o_almost_full,
  output logic                             o_overflow,
  input  logic                             i_flush,
  input  logic                             i_flush_en,
  input  logic [ReorderBufferTagWidth-1:0] i_flush_tag,
  input  logic [ReorderBufferTagWidth-1:0] i_rob_head_tag
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  fu_complete_t     mem [DEPTH];
  logic [DEPTH-1:0] live;
  logic [PtrW-1:0]  rptr;
  logic [PtrW-1:0]  wptr;
  logic [CntW-1:0]  count;
  logic             overflow;

  fu_complete_t head;
  logic         head_kill;
  logic         in_kill;
  logic         in_ok;
  logic         fifo_req;
  logic         bypass_sel;
  logic         full;
  logic         pop;
  logic         push;
  logic         store;

  always_comb begin
    head      = mem[rptr];
    head_kill = i_flush | (i_flush_en & is_younger(head.tag, i_flush_tag, i_rob_head_tag));
    in_kill   = i_flush | (i_flush_en & is_younger(i_fu_complete.tag, i_flush_tag, i_rob_head_tag));
    in_ok     = i_fu_complete.valid & ~in_kill;
    // A same-cycle flush masks the request so a killed head is never granted.
    fifo_req  = (count != '0) & live[rptr] & ~head_kill;
    full      = (count == CntW'(DEPTH));
`ifdef FU_CDB_ADAPTER_BYPASS_EN
    bypass_sel = in_ok & ~|live;
`else
    bypass_sel = 1'b0;
`endif
    pop   = (fifo_req & i_grant) | ((count != '0) & ~live[rptr]);
    push  = in_ok & ~(bypass_sel & i_grant);
    store = push & (~full | pop);

    o_fu_complete       = head;
    o_fu_complete.valid = fifo_req;
`ifdef FU_CDB_ADAPTER_BYPASS_EN
    if (bypass_sel) begin
      o_fu_complete = i_fu_complete;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      live     <= '0;
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (i_flush | (i_flush_en & is_younger(mem[i].tag, i_flush_tag, i_rob_head_tag))) begin
          live[i] <= 1'b0;
        end
      end
      if (pop) begin
        live[rptr] <= 1'b0;
        rptr       <= rptr + PtrW'(1);
      end
      // At full with a pop, wptr == rptr: the push write must win over the pop clear.
      if (store) begin
        mem[wptr]  <= i_fu_complete;
        live[wptr] <= 1'b1;
        wptr       <= wptr + PtrW'(1);
      end else if (push) begin
        overflow <= 1'b1;
      end
      count <= count + CntW'(store) - CntW'(pop);
    end
  end

  assign o_almost_full = (count >= CntW'(DEPTH - 1));
  assign o_overflow    = overflow;

endmodule

// File: tb/tb_fu_cdb_adapter.sv
// Self-checking bench for fu_cdb_adapter: directed plan steps then random traffic against a queue model.
module tb_fu_cdb_adapter;
  import riscv_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned TW    = ReorderBufferTagWidth;
  localparam int          RING  = 1 << TW;
`ifdef FU_CDB_ADAPTER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  fu_complete_t   fin;
  fu_complete_t   fout;
  logic           grant;
  logic           afull;
  logic           ovf;
  logic           flush;
  logic           flush_en;
  logic [TW-1:0]  ftag;
  logic [TW-1:0]  rhead;

  always #5 clk = ~clk;

  fu_cdb_adapter #(.DEPTH(DEPTH)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_fu_complete  (fin),
    .o_fu_complete  (fout),
    .i_grant        (grant),
    .o_almost_full  (afull),
    .o_overflow     (ovf),
    .i_flush        (flush),
    .i_flush_en     (flush_en),
    .i_flush_tag    (ftag),
    .i_rob_head_tag (rhead)
  );

  typedef struct {
    logic [TW-1:0] tag;
    logic [31:0]   value;
    bit            live;
  } ent_t;

  ent_t q[$];
  bit   m_ovf;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Distance from the ROB head around the tag ring; larger distance means younger.
  function automatic int ring_age(logic [TW-1:0] t);
    return (int'(t) - int'(rhead) + RING) % RING;
  endfunction

  function automatic bit killed(logic [TW-1:0] t);
    return flush || (flush_en && (ring_age(t) > ring_age(ftag)));
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fin = '0;
    grant = 1'b0; flush = 1'b0; flush_en = 1'b0; ftag = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic step(bit v, logic [TW-1:0] t, logic [31:0] val, bit g, bit fl, bit fe, logic [TW-1:0] ft);
    bit any_live, byp, freq, pop, push;
    int sz;
    fin.valid = v; fin.tag = t; fin.value = val;
    grant = g; flush = fl; flush_en = fe; ftag = ft;
    any_live = 1'b0;
    foreach (q[i]) if (q[i].live) any_live = 1'b1;
    byp  = BYP && !any_live && v && !killed(t);
    freq = (q.size() > 0) && q[0].live && !killed(q[0].tag);
    @(negedge clk);
    chk("valid", 32'(fout.valid), 32'(byp || freq));
    if (byp) begin
      chk("tag", 32'(fout.tag), 32'(t));
      chk("value", fout.value, val);
    end else if (freq) begin
      chk("tag", 32'(fout.tag), 32'(q[0].tag));
      chk("value", fout.value, q[0].value);
    end
    chk("almost_full", 32'(afull), 32'(q.size() >= DEPTH - 1));
    chk("overflow", 32'(ovf), 32'(m_ovf));
    @(posedge clk);
    pop  = (freq && g) || ((q.size() > 0) && !q[0].live);
    push = v && !killed(t) && !(byp && g);
    sz   = q.size();
    foreach (q[i]) if (killed(q[i].tag)) q[i].live = 1'b0;
    if (pop) void'(q.pop_front());
    if (push) begin
      if (sz < int'(DEPTH) || pop) q.push_back('{tag: t, value: val, live: 1'b1});
      else m_ovf = 1'b1;
    end
    #1;
  endtask

  task automatic idle(bit g);
    step(1'b0, '0, '0, g, 1'b0, 1'b0, '0);
  endtask

  initial begin
    rhead = '0;
    do_reset();
    idle(1'b0);

    // single push with grant held
    step(1'b1, 5, 32'h1234, 1'b1, 1'b0, 1'b0, '0);
    idle(1'b1);
    idle(1'b1);

    // two pushes, grant low, then drain back to back
    step(1'b1, 3, 32'hA003, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 4, 32'hA004, 1'b0, 1'b0, 1'b0, '0);
    repeat (4) idle(1'b0);
    repeat (3) idle(1'b1);

    // partial flush: tag 2 survives, tag 6 drains unseen
    step(1'b1, 2, 32'hB002, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 6, 32'hB006, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 4);
    idle(1'b0);
    repeat (3) idle(1'b1);

    // full flush with same-cycle push
    step(1'b1, 1, 32'hC001, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 2, 32'hC002, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 7, 32'hC007, 1'b1, 1'b1, 1'b0, '0);
    repeat (3) idle(1'b1);

    // full: push with grant, then push without grant -> sticky overflow
    step(1'b1, 10, 32'hD00A, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 11, 32'hD00B, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 9, 32'hD009, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 12, 32'hD00C, 1'b0, 1'b0, 1'b0, '0);
    repeat (4) idle(1'b1);

    // reset with a full buffer
    step(1'b1, 13, 32'hE00D, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 14, 32'hE00E, 1'b0, 1'b0, 1'b0, '0);
    do_reset();
    idle(1'b0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      rhead = TW'($urandom);
      step($urandom_range(99) < 60, TW'($urandom), $urandom, $urandom_range(99) < 50,
           $urandom_range(99) < 5, $urandom_range(99) < 12, TW'($urandom));
      if ($urandom_range(199) == 0) begin
        do_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
